// File: rtl/ui_pkg.sv
// Shared definitions for the labkit user-interface front end: button indices,
// input counts, and the fixed key priority used by the press arbiter.
package ui_pkg;

  localparam int unsigned BTN_ENTER = 0;
  localparam int unsigned BTN_UP    = 1;
  localparam int unsigned BTN_DOWN  = 2;
  localparam int unsigned BTN_LEFT  = 3;
  localparam int unsigned BTN_RIGHT = 4;

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned NUM_SW  = 8;

  typedef logic [NUM_BTN-1:0] btn_vec_t;
  typedef logic [NUM_SW-1:0]  sw_vec_t;

  // Highest priority first: enter > left > right > up > down.
  localparam logic [2:0] BTN_PRIO [NUM_BTN] = '{
    3'(BTN_ENTER), 3'(BTN_LEFT), 3'(BTN_RIGHT), 3'(BTN_UP), 3'(BTN_DOWN)
  };

  function automatic btn_vec_t arbitrate(input btn_vec_t req);
    btn_vec_t gnt;
    logic     found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (!found && req[BTN_PRIO[i]]) begin
        gnt[BTN_PRIO[i]] = 1'b1;
        found            = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One-bit two-flop synchronizer followed by a consecutive-disagreement debouncer.
// Input must already be normalised to 1 = asserted.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter logic        RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync2_q;
      else                                  cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= RST_VAL;
      sync2_q  <= RST_VAL;
      stable_q <= RST_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/button_conditioner.sv
// Labkit button/switch front end: debounced levels, press detection, auto-repeat,
// pending buffer and a priority arbiter emitting one registered pulse per cycle.
module button_conditioner
  import ui_pkg::*;
#(
  parameter int unsigned        ACTIVE_LOW      = 1,
  parameter int unsigned        DEBOUNCE_CYCLES = 270000,
  parameter int unsigned        REPEAT_DELAY    = 13500000,
  parameter int unsigned        REPEAT_PERIOD   = 2700000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 5'b00110
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_SW-1:0]  sw_raw,
  output logic              enter,
  output logic              up,
  output logic              down,
  output logic              left,
  output logic              right,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_SW-1:0]  sw_db
);

  localparam int unsigned HW = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned PW = $clog2(REPEAT_PERIOD + 1);

  btn_vec_t btn_norm, level, level_q;
  btn_vec_t press, rpt, evt;
  btn_vec_t pend_q, pend_d, grant, pulse_q;
  sw_vec_t  sw_level;

  logic [HW-1:0] hold_q [NUM_BTN];
  logic [HW-1:0] hold_d [NUM_BTN];
  logic [PW-1:0] per_q  [NUM_BTN];
  logic [PW-1:0] per_d  [NUM_BTN];

  assign btn_norm = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_cell (
      .clk(clk), .reset(reset), .raw_i(btn_norm[g]), .level_o(level[g])
    );
  end

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_cell (
      .clk(clk), .reset(reset), .raw_i(sw_raw[g]), .level_o(sw_level[g])
    );
  end

  // Hold counter saturates at REPEAT_DELAY; a separate period counter then paces
  // the repeats so nothing ever wraps into a spurious event.
  always_comb begin
    rpt = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      hold_d[i] = '0;
      per_d[i]  = '0;
      if (level[i]) begin
        if (hold_q[i] != HW'(REPEAT_DELAY)) begin
          hold_d[i] = hold_q[i] + 1'b1;
        end else begin
          hold_d[i] = hold_q[i];
          rpt[i]    = REPEAT_MASK[i] && (per_q[i] == '0);
          if (per_q[i] != PW'(REPEAT_PERIOD - 1)) per_d[i] = per_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = level & ~level_q;
  assign evt   = press | rpt;
  assign grant = arbitrate(pend_q);
  // Set after clear so a new event arriving on the grant cycle is kept.
  assign pend_d = (pend_q & ~grant) | evt;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      pend_q  <= '0;
      pulse_q <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        hold_q[i] <= '0;
        per_q[i]  <= '0;
      end
    end else begin
      level_q <= level;
      pend_q  <= pend_d;
      pulse_q <= grant;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        hold_q[i] <= hold_d[i];
        per_q[i]  <= per_d[i];
      end
    end
  end

  assign enter     = pulse_q[BTN_ENTER];
  assign up        = pulse_q[BTN_UP];
  assign down      = pulse_q[BTN_DOWN];
  assign left      = pulse_q[BTN_LEFT];
  assign right     = pulse_q[BTN_RIGHT];
  assign btn_level = level;
  assign sw_db     = sw_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner: bounce, auto-repeat,
// simultaneous presses, pending merge, and reset behaviour.
module tb_button_conditioner;

  logic       clk;
  logic       reset;
  logic [4:0] btn_raw;
  logic [7:0] sw_raw;
  logic       enter, up, down, left, right;
  logic [4:0] btn_level;
  logic [7:0] sw_db;

  logic [4:0] f_btn_raw;
  logic [7:0] f_sw_raw;
  logic       f_enter, f_up, f_down, f_left, f_right;
  logic [4:0] f_btn_level;
  logic [7:0] f_sw_db;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;
  int cnt_pulse [5];
  int f_cnt_up    = 0;
  int f_cnt_enter = 0;
  int f_enter_cyc = -1;
  int up_times [$];
  int exp_up [6] = '{8, 28, 36, 44, 52, 60};
  int rel;

  button_conditioner #(
    .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8), .REPEAT_MASK(5'b00110)
  ) u_dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .enter(enter), .up(up), .down(down), .left(left), .right(right),
    .btn_level(btn_level), .sw_db(sw_db)
  );

  // Active-low instance with a one-cycle repeat period to exercise merging.
  button_conditioner #(
    .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(2),
    .REPEAT_PERIOD(1), .REPEAT_MASK(5'b00110)
  ) u_fast (
    .clk(clk), .reset(reset), .btn_raw(f_btn_raw), .sw_raw(f_sw_raw),
    .enter(f_enter), .up(f_up), .down(f_down), .left(f_left), .right(f_right),
    .btn_level(f_btn_level), .sw_db(f_sw_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [4:0] p, fp;
    @(posedge clk);
    #1;
    cyc++;
    p  = {right, left, down, up, enter};
    fp = {f_right, f_left, f_down, f_up, f_enter};
    check("onehot_main", 32'($countones(p) <= 1), 32'd1);
    check("onehot_fast", 32'($countones(fp) <= 1), 32'd1);
    for (int i = 0; i < 5; i++) cnt_pulse[i] += int'(p[i]);
    if (up) up_times.push_back(cyc);
    f_cnt_up    += int'(f_up);
    f_cnt_enter += int'(f_enter);
    if (f_enter) f_enter_cyc = cyc;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 5; i++) cnt_pulse[i] = 0;
    up_times.delete();
  endtask

  initial begin
    reset     = 1'b1;
    btn_raw   = 5'b00000;
    sw_raw    = 8'h00;
    f_btn_raw = 5'b11111;
    f_sw_raw  = 8'h00;
    clear_counts();
    run(3);
    check("rst_pulses", {27'd0, right, left, down, up, enter}, 32'd0);
    check("rst_btn_level", btn_level, 32'd0);
    check("rst_sw_db", sw_db, 32'd0);
    check("rst_fast_level", f_btn_level, 32'd0);
    reset = 1'b0;
    run(10);
    check("idle_btn_level", btn_level, 32'd0);
    check("idle_fast_level", f_btn_level, 32'd0);

    // Bounce on enter, final rising edge then held.
    clear_counts();
    btn_raw[0] = 1'b1; tick();
    btn_raw[0] = 1'b0; tick();
    btn_raw[0] = 1'b1; tick();
    btn_raw[0] = 1'b0; tick();
    check("bounce_no_pulse", cnt_pulse[0], 32'd0);
    btn_raw[0] = 1'b1;
    run(5);
    check("bounce_level_early", btn_level, 32'd0);
    run(1);
    check("bounce_level", btn_level, 32'b00001);
    run(1);
    check("bounce_pulse_early", enter, 32'd0);
    run(1);
    check("bounce_pulse", enter, 32'd1);
    run(10);
    check("bounce_count", cnt_pulse[0], 32'd1);
    check("bounce_level_held", btn_level[0], 32'd1);
    btn_raw[0] = 1'b0;
    run(10);
    check("release_level", btn_level, 32'd0);
    check("release_no_event", cnt_pulse[0], 32'd1);

    // Auto-repeat on up held for 60 debounced cycles.
    clear_counts();
    btn_raw[1] = 1'b1;
    base = cyc;
    run(60);
    btn_raw[1] = 1'b0;
    run(20);
    check("repeat_count", up_times.size(), 32'd6);
    for (int k = 0; k < 6; k++) begin
      rel = (k < up_times.size()) ? up_times[k] - base : -1;
      check($sformatf("repeat_time%0d", k), rel, exp_up[k]);
    end

    // Left has no auto-repeat.
    clear_counts();
    btn_raw[3] = 1'b1;
    run(60);
    btn_raw[3] = 1'b0;
    run(20);
    check("left_count", cnt_pulse[3], 32'd1);
    check("left_no_others", cnt_pulse[0] + cnt_pulse[1] + cnt_pulse[2] + cnt_pulse[4], 32'd0);

    // Simultaneous right, down, enter.
    clear_counts();
    btn_raw = 5'b10101;
    run(8);
    check("simul_c0", {27'd0, right, left, down, up, enter}, 32'b00001);
    run(1);
    check("simul_c1", {27'd0, right, left, down, up, enter}, 32'b10000);
    run(1);
    check("simul_c2", {27'd0, right, left, down, up, enter}, 32'b00100);
    run(1);
    check("simul_c3", {27'd0, right, left, down, up, enter}, 32'b00000);
    run(4);
    btn_raw = 5'b00000;
    run(15);
    check("simul_total", cnt_pulse[0] + cnt_pulse[2] + cnt_pulse[4], 32'd3);
    check("simul_down_once", cnt_pulse[2], 32'd1);

    // Merge on the active-low instance: up repeating every cycle, enter blocks once.
    f_cnt_up    = 0;
    f_cnt_enter = 0;
    f_enter_cyc = -1;
    f_btn_raw = 5'b11101;
    base = cyc;
    run(10);
    f_btn_raw = 5'b11100;
    run(20);
    f_btn_raw = 5'b11110;
    run(15);
    f_btn_raw = 5'b11111;
    run(10);
    check("merge_enter_count", f_cnt_enter, 32'd1);
    check("merge_enter_time", f_enter_cyc - base, 32'd18);
    check("merge_up_count", f_cnt_up, 32'd28);

    // Reset two cycles into a switch debounce.
    sw_raw = 8'hA5;
    run(2);
    reset = 1'b1;
    run(1);
    check("sw_rst0", sw_db, 32'd0);
    run(2);
    check("sw_rst1", sw_db, 32'd0);
    reset = 1'b0;
    run(5);
    check("sw_early", sw_db, 32'd0);
    run(1);
    check("sw_settled", sw_db, 32'hA5);

    // Right held across a reset pulse that lands just before its pulse.
    clear_counts();
    btn_raw[4] = 1'b1;
    run(7);
    check("held_pre_rst", cnt_pulse[4], 32'd0);
    reset = 1'b1;
    tick();
    check("held_rst_pulse0", {27'd0, right, left, down, up, enter}, 32'd0);
    check("held_rst_level", btn_level, 32'd0);
    tick();
    check("held_rst_pulse1", {27'd0, right, left, down, up, enter}, 32'd0);
    reset = 1'b0;
    run(7);
    check("held_post_early", cnt_pulse[4], 32'd0);
    run(1);
    check("held_post_pulse", right, 32'd1);
    run(10);
    check("held_post_count", cnt_pulse[4], 32'd1);
    btn_raw[4] = 1'b0;
    run(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
